// File: rtl/aer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aer_pkg
// Description : Shared AER event encoding constants, the event builder helper
//               and the rate-encoder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package aer_pkg;

  // AER address layout: [11:10] event type, [9:0] payload
  localparam int AER_WIDTH    = 12;
  localparam int AER_TYPE_MSB = 11;
  localparam int AER_TYPE_LSB = 10;
  localparam int AER_PAY_W    = AER_TYPE_LSB;

  localparam logic [1:0] AER_TYPE_SPIKE = 2'b00;
  localparam logic [1:0] AER_TYPE_MARK  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_EVAL     = 3'd2,
    ST_REQ_HI   = 3'd3,
    ST_REQ_LO   = 3'd4,
    ST_NEXT     = 3'd5,
    ST_MARK_CHK = 3'd6,
    ST_DONE     = 3'd7
  } enc_state_t;

  // Build one AER address from an event type and a payload
  function automatic logic [AER_WIDTH-1:0] aer_event(input logic [1:0] typ,
                                                     input logic [AER_PAY_W-1:0] payload);
    return {typ, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aer_rate_encoder_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR (taps 16/14/13/11, shift left) with a
//               synchronous seed load and an advance enable. Not built when
//               RATE_ENC_DIRECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef RATE_ENC_DIRECT_EN
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        en,
  output logic [15:0] state
);

  logic feedback;
  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  // Load has priority so a new sample always starts from the seed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[14:0], feedback};
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/aer_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module      : aer_rate_encoder
// Description : Stores one frame of pixel intensities and emits rate-coded
//               spike events plus one end-of-step marker per time step on a
//               four-phase AER bus. DONE pulses after the final marker.
//               Build option RATE_ENC_DIRECT_EN selects deterministic
//               threshold coding instead of the LFSR-driven stochastic rule.
// Revision    : 1.0 - initial release
// ============================================================================
module aer_rate_encoder
  import aer_pkg::*;
#(
  parameter int          TIME_STEP    = 8,
  parameter int          INPUT_NEURON = 784,
  parameter int          AER_WIDTH    = aer_pkg::AER_WIDTH,
  parameter int          PIX_WIDTH    = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         PIX_WE,
  input  logic [9:0]                   PIX_WADDR,
  input  logic [PIX_WIDTH-1:0]         PIX_WDATA,
  input  logic                         START,
  output logic [AER_WIDTH-1:0]         AERIN_ADDR,
  output logic                         AERIN_REQ,
  input  logic                         AERIN_ACK,
  output logic [$clog2(TIME_STEP):0]   TS_CNT,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int IDX_W  = 10;
  localparam int TS_W   = $clog2(TIME_STEP) + 1;
  localparam int MEM_AW = $clog2(INPUT_NEURON);

  localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(INPUT_NEURON - 1);
  localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(TIME_STEP - 1);

  enc_state_t            state, state_n;
  logic [IDX_W-1:0]      pix_idx, pix_idx_n;
  logic [TS_W-1:0]       ts, ts_n;
  logic [AER_WIDTH-1:0]  addr, addr_n;
  logic                  mark_pend, mark_pend_n;
  logic                  req_n, busy_n, done_n;

  logic [PIX_WIDTH-1:0]  mem [0:INPUT_NEURON-1];
  logic [PIX_WIDTH-1:0]  pix_rd;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic                  spike;

  // ---------------------------------------------------------------------------
  // Pixel buffer: one shared address, writes only while idle and in range
  // ---------------------------------------------------------------------------
  assign mem_we   = (state == ST_IDLE) && PIX_WE && (int'(PIX_WADDR) < INPUT_NEURON);
  assign mem_addr = mem_we ? PIX_WADDR : pix_idx;

  // Buffer has no reset so the stored frame survives RST
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_addr[MEM_AW-1:0]] <= PIX_WDATA;
    end
    if (state == ST_RD) begin
      pix_rd <= mem[mem_addr[MEM_AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Spike decision
  // ---------------------------------------------------------------------------
`ifdef RATE_ENC_DIRECT_EN
  localparam logic [PIX_WIDTH-1:0] DIRECT_THR = PIX_WIDTH'(128);

  assign spike = (pix_rd >= DIRECT_THR);
`else
  logic [15:0] lfsr_q;
  logic        lfsr_load;
  logic        lfsr_en;
  logic        unused_lfsr_hi;

  // Reseed on every accepted START; advance once for every evaluated pixel
  assign lfsr_load      = (state == ST_IDLE) && START;
  assign lfsr_en        = (state == ST_EVAL);
  assign unused_lfsr_hi = ^lfsr_q[15:8];

  lfsr16 #(
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .RST   (RST),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .state (lfsr_q)
  );

  assign spike = (pix_rd != '0) && (pix_rd >= lfsr_q[7:0]);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state and datapath registers
  // ---------------------------------------------------------------------------
  // Register state, counters, the event address and the registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      pix_idx   <= '0;
      ts        <= '0;
      addr      <= '0;
      mark_pend <= 1'b0;
      AERIN_REQ <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      pix_idx   <= pix_idx_n;
      ts        <= ts_n;
      addr      <= addr_n;
      mark_pend <= mark_pend_n;
      AERIN_REQ <= req_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
    end
  end

  // Next-state logic; outputs follow the next state so REQ rises with ADDR
  always_comb begin
    state_n     = state;
    pix_idx_n   = pix_idx;
    ts_n        = ts;
    addr_n      = addr;
    mark_pend_n = mark_pend;

    case (state)
      ST_IDLE: begin
        if (START) begin
          state_n     = ST_RD;
          pix_idx_n   = '0;
          ts_n        = '0;
          mark_pend_n = 1'b0;
        end
      end
      ST_RD: begin
        state_n = ST_EVAL;
      end
      ST_EVAL: begin
        if (spike) begin
          addr_n      = AER_WIDTH'(aer_event(AER_TYPE_SPIKE, pix_idx));
          mark_pend_n = 1'b0;
          state_n     = ST_REQ_HI;
        end else begin
          state_n = ST_NEXT;
        end
      end
      ST_REQ_HI: begin
        if (AERIN_ACK) begin
          state_n = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (!AERIN_ACK) begin
          state_n = mark_pend ? ST_MARK_CHK : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (pix_idx == LAST_PIX) begin
          addr_n      = AER_WIDTH'(aer_event(AER_TYPE_MARK, AER_PAY_W'(ts)));
          mark_pend_n = 1'b1;
          state_n     = ST_REQ_HI;
        end else begin
          pix_idx_n = pix_idx + 1'b1;
          state_n   = ST_RD;
        end
      end
      ST_MARK_CHK: begin
        if (ts == LAST_TS) begin
          state_n = ST_DONE;
        end else begin
          ts_n      = ts + 1'b1;
          pix_idx_n = '0;
          state_n   = ST_RD;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    req_n  = (state_n == ST_REQ_HI);
    busy_n = (state_n != ST_IDLE) && (state_n != ST_DONE);
    done_n = (state_n == ST_DONE);
  end

  assign AERIN_ADDR = addr;
  assign TS_CNT     = ts;

endmodule
`default_nettype wire

// File: tb/tb_aer_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_aer_rate_encoder
// Description : Scoreboard bench for aer_rate_encoder. A reference model
//               expands each frame into the expected event stream; a monitor
//               pops and compares on every REQ rise. Small frame size keeps
//               run time short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_rate_encoder;

  localparam int TS = 8;
  localparam int NP = 128;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PIX_WE = 1'b0;
  logic [9:0]  PIX_WADDR = '0;
  logic [7:0]  PIX_WDATA = '0;
  logic        START = 1'b0;
  logic [11:0] AERIN_ADDR;
  logic        AERIN_REQ;
  logic        AERIN_ACK = 1'b0;
  logic [3:0]  TS_CNT;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  frame [NP];
  int          exp_spk [NP];
  int          obs_spk [NP];
  int          ev_cnt, spk_total, done_cnt, ack_fall_cyc;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_dly = 1;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [11:0] held;

  aer_rate_encoder #(
    .TIME_STEP    (TS),
    .INPUT_NEURON (NP),
    .AER_WIDTH    (12),
    .PIX_WIDTH    (8),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PIX_WE     (PIX_WE),
    .PIX_WADDR  (PIX_WADDR),
    .PIX_WDATA  (PIX_WDATA),
    .START      (START),
    .AERIN_ADDR (AERIN_ADDR),
    .AERIN_REQ  (AERIN_REQ),
    .AERIN_ACK  (AERIN_ACK),
    .TS_CNT     (TS_CNT),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Core-side responder: ACK follows REQ after ack_dly cycles
  initial begin
    forever begin
      @(negedge CLK);
      if (!ack_en) begin
        AERIN_ACK = 1'b0;
      end else if (AERIN_REQ && !AERIN_ACK) begin
        repeat (ack_dly) @(posedge CLK);
        #1;
        if (ack_en) AERIN_ACK = 1'b1;
      end else if (!AERIN_REQ && AERIN_ACK) begin
        repeat (ack_dly) @(posedge CLK);
        #1;
        AERIN_ACK = 1'b0;
      end
    end
  end

  // Monitor: pop/compare on REQ rise, address stability during handshake
  always @(negedge CLK) begin
    if (mon_en) begin
      if (AERIN_REQ && !prev_req) begin
        total++;
        ev_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL event_extra: got addr=%h, required no event", AERIN_ADDR);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (AERIN_ADDR !== e) begin
            bad++;
            $display("FAIL event_addr: got %h, required %h", AERIN_ADDR, e);
          end
        end
        held = AERIN_ADDR;
        if (AERIN_ADDR[11:10] == 2'b00 && int'(AERIN_ADDR[9:0]) < NP) begin
          obs_spk[AERIN_ADDR[9:0]]++;
          spk_total++;
        end
      end else if ((AERIN_REQ || AERIN_ACK) && (prev_req || prev_ack)) begin
        total++;
        if (AERIN_ADDR !== held) begin
          bad++;
          $display("FAIL addr_stable: got %h, required %h", AERIN_ADDR, held);
        end
      end
      if (prev_ack && !AERIN_ACK) ack_fall_cyc = cyc;
      if (DONE) done_cnt++;
    end
    prev_req = AERIN_REQ;
    prev_ack = AERIN_ACK;
  end

  // Reference model: expand frame into the expected event stream
  task automatic build_expected();
    logic [15:0] s;
    logic        hit;
    s = 16'hACE1;
    for (int p = 0; p < NP; p++) exp_spk[p] = 0;
    for (int t = 0; t < TS; t++) begin
      for (int p = 0; p < NP; p++) begin
`ifdef RATE_ENC_DIRECT_EN
        hit = (frame[p] >= 8'd128);
`else
        hit = (frame[p] != 8'd0) && (frame[p] >= s[7:0]);
        s   = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
`endif
        if (hit) begin
          exp_q.push_back({2'b00, 10'(p)});
          exp_spk[p]++;
        end
      end
      exp_q.push_back({2'b01, 10'(t)});
    end
  endtask

  task automatic clear_counts();
    ev_cnt = 0; spk_total = 0; done_cnt = 0; ack_fall_cyc = -100;
    for (int p = 0; p < NP; p++) obs_spk[p] = 0;
  endtask

  task automatic load_frame();
    for (int p = 0; p < NP; p++) begin
      @(negedge CLK);
      PIX_WE = 1'b1; PIX_WADDR = 10'(p); PIX_WDATA = frame[p];
    end
    @(negedge CLK);
    PIX_WE = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic run_to_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (DONE) begin #1; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    total++; if (AERIN_REQ !== 1'b0) begin bad++; $display("FAIL reset_req: got %b, required 0", AERIN_REQ); end
    total++; if (AERIN_ADDR !== 12'h000) begin bad++; $display("FAIL reset_addr: got %h, required 000", AERIN_ADDR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", DONE); end
    total++; if (TS_CNT !== 4'd0) begin bad++; $display("FAIL reset_ts: got %0d, required 0", TS_CNT); end
    @(negedge CLK); RST = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_all_zero();
    bit ok;
    for (int p = 0; p < NP; p++) frame[p] = 8'd0;
    load_frame();
    // Out-of-range writes must be dropped
    for (int p = NP; p < NP + 8; p++) begin
      @(negedge CLK); PIX_WE = 1'b1; PIX_WADDR = 10'(p); PIX_WDATA = 8'hFF;
    end
    @(negedge CLK); PIX_WE = 1'b0;
    clear_counts(); build_expected();
    pulse_start();
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b, required 1", BUSY); end
    run_to_done(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_done_timeout: got no DONE, required DONE"); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL zero_busy_at_done: got %b, required 0", BUSY); end
    total++; if (cyc - ack_fall_cyc != 2) begin bad++; $display("FAIL zero_done_latency: got %0d, required 2", cyc - ack_fall_cyc); end
    total++; if (ev_cnt != TS) begin bad++; $display("FAIL zero_events: got %0d, required %0d", ev_cnt, TS); end
    total++; if (spk_total != 0) begin bad++; $display("FAIL zero_spikes: got %0d, required 0", spk_total); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_count: got %0d, required 1", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zero_queue_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_all_max();
    bit ok;
    for (int p = 0; p < NP; p++) frame[p] = 8'd255;
    load_frame();
    clear_counts(); build_expected();
    pulse_start();
    total++; if (AERIN_REQ !== 1'b0) begin bad++; $display("FAIL max_req_c1: got %b, required 0", AERIN_REQ); end
    @(negedge CLK);
    total++; if (AERIN_REQ !== 1'b0) begin bad++; $display("FAIL max_req_c2: got %b, required 0", AERIN_REQ); end
    @(negedge CLK);
    total++; if (AERIN_REQ !== 1'b1) begin bad++; $display("FAIL max_req_c3: got %b, required 1", AERIN_REQ); end
    run_to_done(30000, ok);
    total++; if (!ok) begin bad++; $display("FAIL max_done_timeout: got no DONE, required DONE"); end
    total++; if (ev_cnt != TS * (NP + 1)) begin bad++; $display("FAIL max_events: got %0d, required %0d", ev_cnt, TS * (NP + 1)); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL max_queue_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_sparse();
    bit ok;
    for (int p = 0; p < NP; p++) frame[p] = 8'd0;
    frame[5] = 8'd128;
    load_frame();
    clear_counts(); build_expected();
    pulse_start();
    run_to_done(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sparse_done_timeout: got no DONE, required DONE"); end
    total++; if (obs_spk[5] != exp_spk[5]) begin bad++; $display("FAIL sparse_pix5: got %0d, required %0d", obs_spk[5], exp_spk[5]); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sparse_queue_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_stoch_64();
    bit ok;
    for (int p = 0; p < NP; p++) frame[p] = 8'd64;
    load_frame();
    // Final write shares its cycle with START and must be used
    frame[NP-1] = 8'd200;
    clear_counts(); build_expected();
    @(negedge CLK);
    START = 1'b1; PIX_WE = 1'b1; PIX_WADDR = 10'(NP - 1); PIX_WDATA = 8'd200;
    @(negedge CLK);
    START = 1'b0; PIX_WE = 1'b0;
    run_to_done(20000, ok);
    total++; if (!ok) begin bad++; $display("FAIL stoch_done_timeout: got no DONE, required DONE"); end
    for (int p = 0; p < NP; p++) begin
      total++;
      if (obs_spk[p] != exp_spk[p]) begin
        bad++; $display("FAIL stoch_pix_count[%0d]: got %0d, required %0d", p, obs_spk[p], exp_spk[p]);
      end
    end
`ifndef RATE_ENC_DIRECT_EN
    total++;
    if (spk_total < (TS * NP) / 8 || spk_total > (TS * NP) / 2) begin
      bad++; $display("FAIL stoch_rate: got %0d spikes, required roughly 25%% of %0d", spk_total, TS * NP);
    end
`endif
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stoch_queue_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_delayed_ack();
    bit ok;
    for (int p = 0; p < NP; p++) frame[p] = 8'((p * 37 + 11) & 255);
    load_frame();
    clear_counts(); build_expected();
    ack_dly = 7;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge CLK);
      if (i == 200) begin
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL delay_busy_mid: got %b, required 1", BUSY); end
        START = 1'b1; PIX_WE = 1'b1; PIX_WADDR = 10'd3; PIX_WDATA = ~frame[3];
      end else if (i == 201) begin
        START = 1'b0; PIX_WE = 1'b0;
      end
      if (DONE) begin #1; ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL delay_done_timeout: got no DONE, required DONE"); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL delay_done_count: got %0d, required 1", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL delay_queue_left: got %0d, required 0", exp_q.size()); end
    @(negedge CLK);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL delay_no_restart: got BUSY=%b, required 0", BUSY); end
    ack_dly = 1;
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit found;
    for (int p = 0; p < NP; p++) frame[p] = 8'($urandom_range(0, 255));
    frame[100] = 8'd255;
    load_frame();
    clear_counts(); build_expected();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLK);
      if (AERIN_REQ && AERIN_ADDR == 12'd100 && TS_CNT == 4'd3) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach_px100_ts3: got not reached, required reached"); end
    mon_en = 1'b0; ack_en = 1'b0;
    @(posedge CLK); #3; RST = 1'b1; #1;
    total++; if (AERIN_REQ !== 1'b0) begin bad++; $display("FAIL rst_req: got %b, required 0", AERIN_REQ); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", BUSY); end
    total++; if (TS_CNT !== 4'd0) begin bad++; $display("FAIL rst_ts: got %0d, required 0", TS_CNT); end
    total++; if (AERIN_ADDR !== 12'h000) begin bad++; $display("FAIL rst_addr: got %h, required 000", AERIN_ADDR); end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    exp_q.delete();
    clear_counts(); build_expected();
    ack_en = 1'b1; mon_en = 1'b1;
    pulse_start();
    total++; if (TS_CNT !== 4'd0) begin bad++; $display("FAIL restart_ts: got %0d, required 0", TS_CNT); end
    run_to_done(30000, ok);
    total++; if (!ok) begin bad++; $display("FAIL restart_done_timeout: got no DONE, required DONE"); end
    total++; if (obs_spk[100] != exp_spk[100]) begin bad++; $display("FAIL restart_pix100: got %0d, required %0d", obs_spk[100], exp_spk[100]); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL restart_queue_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    test_reset();
    test_all_zero();
    test_all_max();
    test_sparse();
    test_stoch_64();
    test_delayed_ack();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aer_rate_encoder.md
# aer_rate_encoder

Upstream stimulus stage for the SNN core: holds one input frame of 8-bit pixel intensities and turns it into rate-coded spike events over TIME_STEP time steps. Events go out on the 12-bit four-phase AER input bus (AERIN_ADDR/REQ/ACK) that feeds the ffstdp core. Each time step ends with a marker event. A DONE pulse follows the final step, so the sample controller can sequence IS_POS/IS_TRAIN and read GOODNESS.

## Interface
- TIME_STEP, 8: time steps per sample; a marker event is emitted after each step.
- INPUT_NEURON, 784: pixels per frame; pixel index = AER neuron address.
- AER_WIDTH, 12: AER address width; [11:10] event type, [9:0] payload.
- PIX_WIDTH, 8: pixel intensity width.
- LFSR_SEED, 16'hACE1: nonzero LFSR seed, reloaded on every START.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- PIX_WE  in  1  pixel buffer write strobe; honoured only in IDLE.
- PIX_WADDR  in  10  pixel write index, 0..INPUT_NEURON-1.
- PIX_WDATA  in  PIX_WIDTH  pixel intensity.
- START  in  1  single-cycle pulse: begin encoding the stored frame; honoured only in IDLE.
- AERIN_ADDR  out  AER_WIDTH  event address; reset 0.
- AERIN_REQ  out  1  event request; reset 0.
- AERIN_ACK  in  1  event acknowledge from the core.
- TS_CNT  out  $clog2(TIME_STEP)+1  current time step; reset 0.
- BUSY  out  1  high from START accept to DONE; reset 0.
- DONE  out  1  one-cycle pulse after the last marker handshake completes; reset 0.

## Operation
- Pixel buffer: INPUT_NEURON x PIX_WIDTH single-port RAM with 1-cycle read latency. In IDLE, PIX_WE writes it. Writes outside IDLE and writes with addresses ≥ INPUT_NEURON are dropped.
- Event encoding:
  - Spike: {2'b00, pix_idx}.
  - End-of-step marker: {2'b01, 10'(ts)}.
  - Types 2'b10 and 2'b11 are reserved and never emitted.
- Spike rule, per pixel per step: spike iff pix ≠ 0 and pix ≥ lfsr[7:0]. Pixel 0 never spikes; pixel 255 always spikes.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, shift left. It advances exactly once per evaluated pixel, including pixels that do not spike.
- FSM states:
  - IDLE: START → RD with pix_idx=0, ts=0, lfsr=LFSR_SEED, BUSY=1.
  - RD: issue buffer read of pix_idx → EVAL.
  - EVAL: apply spike rule, advance LFSR. Spike → REQ_HI with ADDR loaded. No spike → NEXT.
  - REQ_HI: REQ=1 with ADDR held stable; on ACK=1 drop REQ → REQ_LO.
  - REQ_LO: on ACK=0 → NEXT if a spike was pending, or → MARK_CHK if a marker was pending.
  - NEXT: pix_idx==INPUT_NEURON-1 → load marker ADDR, go to REQ_HI with the marker flagged. Otherwise increment pix_idx → RD.
  - MARK_CHK: ts==TIME_STEP-1 → DONE_ST. Otherwise ts+1, pix_idx=0 → RD.
  - DONE_ST: DONE=1 for one cycle, BUSY=0 → IDLE.
- No ACK timeout. The FSM waits indefinitely in REQ_HI or REQ_LO.

## Timing
- Non-spiking pixel: 3 cycles (RD, EVAL, NEXT).
- Spiking pixel: 3 cycles + 2 handshake edges; minimum 5 cycles when ACK returns in 1 cycle.
- Each handshake's first cycle of REQ=1 is no earlier than the cycle after ADDR changes. ADDR never changes while REQ=1 or ACK=1.
- START to first REQ (pixel 0 spiking): 3 cycles.
- Last marker ACK falls → DONE high 2 cycles later. BUSY falls in the same cycle DONE rises.
- START while BUSY: ignored. START and PIX_WE in the same IDLE cycle: the write lands first, and encoding uses the new value.
- RST mid-handshake: REQ, BUSY, DONE, ADDR and TS_CNT clear asynchronously. Buffer contents are preserved. The core must tolerate a REQ drop without ACK.
- ACK already high when entering REQ_HI (protocol violation): treated as acknowledge on that cycle.

## Configuration
- RATE_ENC_DIRECT_EN defined: direct (deterministic) coding.
  - Spike iff pix ≥ 8'd128, identically every step.
  - LFSR is removed and LFSR_SEED is unused.
- Undefined: stochastic LFSR rule as above.

## Structure
- Shared package aer_pkg:
  - Event-type constants AER_TYPE_SPIKE=2'b00 and AER_TYPE_MARK=2'b01.
  - AER_WIDTH and the type-field bit positions.
  - FSM state enum enc_state_t.
- Sub-module lfsr16 (seed load, enable, 16-bit state out). It is excluded from build under RATE_ENC_DIRECT_EN.
- Pixel buffer is inferred inside the block.

## Test plan
- All pixels 0, TIME_STEP=8, ACK echoes REQ after 1 cycle → exactly 8 events, ADDR 0x400..0x407, one DONE, zero spikes.
- All pixels 255 → 8×784 spikes; each step emits ADDR 0x000..0x30F in order, followed by that step's marker.
- Pixel 5 = 128, others 0, RATE_ENC_DIRECT_EN defined → per step exactly ADDR 0x005 then the marker; 16 events total.
- Stochastic mode, frame of all 64 → spike count per pixel matches a golden LFSR model bit-exactly. The total is ≈25% of 6272.
- ACK delayed 7 cycles, plus START pulsed mid-sample and PIX_WE while BUSY → ADDR stable throughout each REQ; START and write ignored; buffer unchanged.
- RST asserted while REQ=1 at pixel 100, step 3 → REQ, BUSY, TS_CNT are 0 the same cycle; a new START restarts at pixel 0, step 0 with the stored frame.
